// File: rtl/board_status_reader.sv
// board_status_reader: streams 3-bit cell statuses out of a snapshot of the
// packed board, either one addressed cell or a full raster scan, and counts
// how many scanned cells equal a requested status.
module board_status_reader #(
    parameter int CELLS_X  = 8,
    parameter int CELLS_Y  = 8,
    parameter int STATUS_W = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CELLS_X*CELLS_Y*STATUS_W-1:0] board_state,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_scan,
    input  logic [3:0]                          req_x,
    input  logic [3:0]                          req_y,
    input  logic [STATUS_W-1:0]                 req_match,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [STATUS_W-1:0]                 rsp_status,
    output logic [3:0]                          rsp_x,
    output logic [3:0]                          rsp_y,
    output logic                                rsp_last,
    output logic                                rsp_oob,
    output logic [6:0]                          match_count
);

    localparam int NCELLS = CELLS_X * CELLS_Y;
    localparam int BW     = NCELLS * STATUS_W;
    localparam int IW     = $clog2(NCELLS);

    localparam logic [3:0] X_MAX = 4'(CELLS_X - 1);
    localparam logic [3:0] Y_MAX = 4'(CELLS_Y - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SINGLE = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [BW-1:0]       snap_q, snap_d;
    logic [3:0]          x_q, x_d;
    logic [3:0]          y_q, y_d;
    logic [STATUS_W-1:0] match_q, match_d;
    logic [6:0]          cnt_q, cnt_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic [STATUS_W-1:0] rsp_status_q, rsp_status_d;
    logic [3:0]          rsp_x_q, rsp_x_d;
    logic [3:0]          rsp_y_q, rsp_y_d;
    logic                rsp_last_q, rsp_last_d;
    logic                rsp_oob_q, rsp_oob_d;
    logic [6:0]          match_count_q, match_count_d;

    // Coordinates, status and flags of the beat that would be loaded next.
    logic [3:0]          rd_x, rd_y;
    logic [IW-1:0]       rd_idx;
    logic [STATUS_W-1:0] rd_status;
    logic                rd_oob, rd_last, rd_hit;

    logic                hs;
    logic [6:0]          cnt_base;

    // Per-cell view of the snapshot so a cell can be picked by linear index.
    logic [STATUS_W-1:0] snap_cell [NCELLS];
    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        assign snap_cell[i] = snap_q[i*STATUS_W +: STATUS_W];
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_x       = rsp_x_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_last    = rsp_last_q;
    assign rsp_oob     = rsp_oob_q;
    assign match_count = match_count_q;

    assign hs = rsp_valid_q && rsp_ready;

    // Pick the next beat's cell: latched coords for a single read, otherwise
    // (0,0) for the first scan beat and the raster successor afterwards.
    always_comb begin
        rd_x = x_q;
        rd_y = y_q;
        if (state_q == S_SCAN) begin
            if (!rsp_valid_q) begin
                rd_x = 4'd0;
                rd_y = 4'd0;
            end else if (rsp_x_q == X_MAX) begin
                rd_x = 4'd0;
                rd_y = rsp_y_q + 4'd1;
            end else begin
                rd_x = rsp_x_q + 4'd1;
                rd_y = rsp_y_q;
            end
        end
        rd_oob    = (state_q == S_SINGLE) && ((rd_x > X_MAX) || (rd_y > Y_MAX));
        rd_idx    = IW'(rd_y) * IW'(CELLS_X) + IW'(rd_x);
        rd_status = rd_oob ? '0 : snap_cell[rd_idx];
        rd_last   = (state_q != S_SCAN) || ((rd_x == X_MAX) && (rd_y == Y_MAX));
        rd_hit    = (rd_status == match_q);
    end

    // Transaction control: accept in IDLE, then present beats until the
    // last one is handshaken. The match count is updated on each handshake
    // and the final total is published together with the last beat.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        x_d           = x_q;
        y_d           = y_q;
        match_d       = match_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_x_d       = rsp_x_q;
        rsp_y_d       = rsp_y_q;
        rsp_last_d    = rsp_last_q;
        rsp_oob_d     = rsp_oob_q;
        match_count_d = match_count_q;

        cnt_base = cnt_q;
        if (hs && (rsp_status_q == match_q)) begin
            cnt_base = cnt_q + 7'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d       = req_scan ? S_SCAN : S_SINGLE;
                    snap_d        = board_state;
                    x_d           = req_x;
                    y_d           = req_y;
                    match_d       = req_match;
                    cnt_d         = 7'd0;
                    match_count_d = 7'd0;
                end
            end
            S_SINGLE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = rd_status;
                    rsp_x_d      = rd_x;
                    rsp_y_d      = rd_y;
                    rsp_last_d   = 1'b1;
                    rsp_oob_d    = rd_oob;
                end else if (hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_SCAN: begin
                if (hs) begin
                    cnt_d = cnt_base;
                end
                if (hs && rsp_last_q) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (!rsp_valid_q || hs) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = rd_status;
                    rsp_x_d      = rd_x;
                    rsp_y_d      = rd_y;
                    rsp_last_d   = rd_last;
                    rsp_oob_d    = 1'b0;
                    if (rd_last) begin
                        match_count_d = cnt_base + {6'd0, rd_hit};
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything including the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            snap_q        <= '0;
            x_q           <= 4'd0;
            y_q           <= 4'd0;
            match_q       <= '0;
            cnt_q         <= 7'd0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= '0;
            rsp_x_q       <= 4'd0;
            rsp_y_q       <= 4'd0;
            rsp_last_q    <= 1'b0;
            rsp_oob_q     <= 1'b0;
            match_count_q <= 7'd0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            x_q           <= x_d;
            y_q           <= y_d;
            match_q       <= match_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_x_q       <= rsp_x_d;
            rsp_y_q       <= rsp_y_d;
            rsp_last_q    <= rsp_last_d;
            rsp_oob_q     <= rsp_oob_d;
            match_count_q <= match_count_d;
        end
    end

endmodule

// File: tb/tb_board_status_reader.sv
// Directed bench for board_status_reader: single reads in and out of range,
// free-running and stalled scans with snapshot coherence, corner match
// counts and a reset in the middle of a scan.
module tb_board_status_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] board_state;
    logic         req_valid;
    logic         req_ready;
    logic         req_scan;
    logic [3:0]   req_x;
    logic [3:0]   req_y;
    logic [2:0]   req_match;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [2:0]   rsp_status;
    logic [3:0]   rsp_x;
    logic [3:0]   rsp_y;
    logic         rsp_last;
    logic         rsp_oob;
    logic [6:0]   match_count;

    int nerr = 0;
    int nchk = 0;

    logic [2:0] cells [64];

    board_status_reader dut (
        .clk         (clk),
        .rst         (rst),
        .board_state (board_state),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_scan    (req_scan),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_match   (req_match),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .rsp_last    (rsp_last),
        .rsp_oob     (rsp_oob),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_board();
        for (int i = 0; i < 64; i++) board_state[i*3 +: 3] = cells[i];
    endtask

    task automatic do_single(input logic [3:0] x, input logic [3:0] y,
                             input logic [2:0] es, input logic eo);
        check("s_rdy", req_ready, 1);
        req_valid = 1'b1; req_scan = 1'b0; req_x = x; req_y = y;
        req_match = 3'd0; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        check("s_lat", rsp_valid, 0);
        check("s_busy", req_ready, 0);
        step();
        check("s_vld", rsp_valid, 1);
        check("s_status", rsp_status, es);
        check("s_x", rsp_x, x);
        check("s_y", rsp_y, y);
        check("s_last", rsp_last, 1);
        check("s_oob", rsp_oob, eo);
        step();
        check("s_hold_vld", rsp_valid, 1);
        check("s_hold_st", rsp_status, es);
        // final handshake with a competing request that must be ignored
        rsp_ready = 1'b1; req_valid = 1'b1; req_scan = 1'b1;
        step();
        rsp_ready = 1'b0; req_valid = 1'b0;
        check("s_done_vld", rsp_valid, 0);
        check("s_done_rdy", req_ready, 1);
        step();
        check("s_noqueue", rsp_valid, 0);
        check("s_idle_rdy", req_ready, 1);
    endtask

    task automatic run_scan(input logic [2:0] m, input bit rnd, input bit corrupt);
        int beat;
        int cyc;
        int exp_cnt;
        bit stalled;
        logic [20:0] held;
        exp_cnt = 0;
        for (int i = 0; i < 64; i++) if (cells[i] == m) exp_cnt++;
        load_board();
        check("sc_rdy", req_ready, 1);
        req_valid = 1'b1; req_scan = 1'b1; req_x = 4'd9; req_y = 4'd9;
        req_match = m; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        if (corrupt) board_state = '1;
        check("sc_lat", rsp_valid, 0);
        step();
        beat = 0; cyc = 0; stalled = 0; held = '0;
        while (beat < 64 && cyc < 2000) begin
            if (stalled)
                check("sc_hold", {rsp_valid, rsp_status, rsp_x, rsp_y, rsp_last, rsp_oob, match_count}, held);
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
            if (rsp_valid && !rsp_ready) begin
                stalled = 1;
                held = {rsp_valid, rsp_status, rsp_x, rsp_y, rsp_last, rsp_oob, match_count};
            end
            if (rsp_valid && rsp_ready) begin
                check("sc_x", rsp_x, beat % 8);
                check("sc_y", rsp_y, beat / 8);
                check("sc_status", rsp_status, cells[beat]);
                check("sc_last", rsp_last, (beat == 63) ? 1 : 0);
                check("sc_oob", rsp_oob, 0);
                check("sc_mcnt", match_count, (beat == 63) ? exp_cnt : 0);
                beat++;
            end
            step();
            cyc++;
        end
        rsp_ready = 1'b0;
        check("sc_beats", beat, 64);
        if (!rnd) check("sc_cycles", cyc, 64);
        check("sc_end_vld", rsp_valid, 0);
        check("sc_end_rdy", req_ready, 1);
        check("sc_end_mcnt", match_count, exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        board_state = '0;
        req_valid = 1'b0; req_scan = 1'b0; req_x = 4'd0; req_y = 4'd0;
        req_match = 3'd0; rsp_ready = 1'b0;
        #12;
        check("rst_vld", rsp_valid, 0);
        check("rst_rdy", req_ready, 1);
        check("rst_outs", {rsp_status, rsp_x, rsp_y, rsp_last, rsp_oob, match_count}, 0);
        step();
        rst = 1'b0;
        step();
        check("rel_rdy", req_ready, 1);

        // single reads
        for (int i = 0; i < 64; i++) cells[i] = 3'd0;
        cells[2*8+5] = 3'b101;
        load_board();
        do_single(4'd5, 4'd2, 3'd5, 1'b0);
        do_single(4'd8, 4'd3, 3'd0, 1'b1);
        do_single(4'd2, 4'd9, 3'd0, 1'b1);
        do_single(4'd0, 4'd0, 3'd0, 1'b0);

        // free-running scan, status i%8, match 3
        for (int i = 0; i < 64; i++) cells[i] = 3'(i % 8);
        run_scan(3'd3, 1'b0, 1'b0);

        // stalled scan with board overwritten after acceptance
        for (int i = 0; i < 64; i++) cells[i] = 3'((i * 3 + i / 8) % 8);
        run_scan(3'd6, 1'b1, 1'b1);

        // corner match counts on an all-zero board
        for (int i = 0; i < 64; i++) cells[i] = 3'd0;
        run_scan(3'd0, 1'b0, 1'b0);
        run_scan(3'd7, 1'b0, 1'b0);

        // reset in the middle of a scan
        for (int i = 0; i < 64; i++) cells[i] = 3'(i % 8);
        load_board();
        req_valid = 1'b1; req_scan = 1'b1; req_match = 3'd1; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 20; i++) step();
        check("mid_x", rsp_x, 4);
        check("mid_y", rsp_y, 2);
        check("mid_vld", rsp_valid, 1);
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_vld", rsp_valid, 0);
        check("mr_rdy", req_ready, 1);
        check("mr_outs", {rsp_status, rsp_x, rsp_y, rsp_last, rsp_oob, match_count}, 0);
        step();
        rst = 1'b0;
        step();
        check("mr_rel_rdy", req_ready, 1);
        check("mr_rel_vld", rsp_valid, 0);
        cells[25] = 3'd6;
        load_board();
        do_single(4'd1, 4'd3, 3'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
